playfield_arbiter: RTL

PLAYFIELD_ARBITER -- requirements
Module: playfield_arbiter

---
 rtl/playfield_if.sv | 38 +++
 rtl/playfield_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/playfield_if.sv
// Bus bundle between the playfield arbiter and its game controller / display reader.
interface playfield_if #(
    parameter int BOARD_W = 12,
    parameter int BOARD_H = 21,
    parameter int CELLS   = 4,
    parameter int COLOR_W = 3
);
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);

    logic [XW-1:0]       rd_x;
    logic [YW-1:0]       rd_y;
    logic [COLOR_W-1:0]  rd_color;
    logic [CELLS*XW-1:0] piece_x;
    logic [CELLS*YW-1:0] piece_y;
    logic [COLOR_W-1:0]  piece_color;
    logic                move_req;
    logic                move_intent;
    logic                move_commit;
    logic                move_declined;
    logic                move_locked;
    logic                busy;
    logic                init_done;
    logic                game_over;
    logic [15:0]         lines_cleared;

    modport master (
        output rd_x, rd_y, piece_x, piece_y, piece_color, move_req, move_intent,
        input  rd_color, move_commit, move_declined, move_locked, busy, init_done,
               game_over, lines_cleared
    );

    modport slave (
        input  rd_x, rd_y, piece_x, piece_y, piece_color, move_req, move_intent,
        output rd_color, move_commit, move_declined, move_locked, busy, init_done,
               game_over, lines_cleared
    );
endinterface

// File: rtl/playfield_arbiter.sv
// Falling-block playfield: stores the board, arbitrates proposed piece moves,
// locks pieces on gravity collisions and clears full rows.
module playfield_arbiter #(
    parameter int                 BOARD_W       = 12,
    parameter int                 BOARD_H       = 21,
    parameter int                 CELLS         = 4,
    parameter int                 COLOR_W       = 3,
    parameter logic [COLOR_W-1:0] WALL_COLOR    = 3'b110,
    parameter int                 SETTLE_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    playfield_if.slave pf
);
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = (CELLS > 1) ? $clog2(CELLS) : 1;

    // INIT paint board | IDLE wait for move | SETTLE input delay | CHECK collision test
    // LOCK write piece one row up | SCAN look for full row | SHIFT drop rows above it
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETTLE, S_CHECK, S_LOCK, S_SCAN, S_SHIFT
    } state_t;

    state_t             state;
    logic [COLOR_W-1:0] field [BOARD_H][BOARD_W];
    logic [XW-1:0]      init_x;
    logic [YW-1:0]      init_y;
    logic [SW-1:0]      settle_cnt;
    logic [CW-1:0]      lock_idx;
    logic [YW-1:0]      scan_row;
    logic [YW-1:0]      shift_row;
    logic               intent;
    logic               commit_q, declined_q, locked_q, init_done_q, game_over_q;
    logic [15:0]        lines_q;

    logic               collide, lock_top, row_full;
    logic [XW-1:0]      lock_x;
    logic [YW-1:0]      lock_y, lock_y_up;
    logic [COLOR_W-1:0] rd_val;

    always_comb begin : collide_calc
        logic [XW-1:0] cx;
        logic [YW-1:0] cy;
        collide  = 1'b0;
        lock_top = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            cx = pf.piece_x[i*XW +: XW];
            cy = pf.piece_y[i*YW +: YW];
            if (cy == '0) lock_top = 1'b1;
            if (int'(cx) >= BOARD_W || int'(cy) >= BOARD_H) collide = 1'b1;
            else if (field[cy][cx] != '0) collide = 1'b1;
        end
    end

    always_comb begin
        lock_x    = pf.piece_x[int'(lock_idx)*XW +: XW];
        lock_y    = pf.piece_y[int'(lock_idx)*YW +: YW];
        lock_y_up = lock_y - YW'(1);
    end

    always_comb begin
        row_full = 1'b1;
        for (int c = 1; c < BOARD_W - 1; c++)
            if (field[scan_row][XW'(c)] == '0) row_full = 1'b0;
    end

    // Display read: the moving piece is overlaid on top of the stored field.
    always_comb begin
        rd_val = '0;
        if (int'(pf.rd_x) < BOARD_W && int'(pf.rd_y) < BOARD_H) begin
            rd_val = field[pf.rd_y][pf.rd_x];
            for (int i = 0; i < CELLS; i++)
                if (pf.piece_x[i*XW +: XW] == pf.rd_x && pf.piece_y[i*YW +: YW] == pf.rd_y)
                    rd_val = pf.piece_color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            init_x      <= '0;
            init_y      <= '0;
            settle_cnt  <= '0;
            lock_idx    <= '0;
            scan_row    <= '0;
            shift_row   <= '0;
            intent      <= 1'b0;
            commit_q    <= 1'b0;
            declined_q  <= 1'b0;
            locked_q    <= 1'b0;
            init_done_q <= 1'b0;
            game_over_q <= 1'b0;
            lines_q     <= '0;
        end else begin
            commit_q   <= 1'b0;
            declined_q <= 1'b0;
            locked_q   <= 1'b0;
            case (state)
                S_INIT: begin
                    field[init_y][init_x] <= (init_x == '0 || int'(init_x) == BOARD_W - 1 ||
                                              int'(init_y) == BOARD_H - 1) ? WALL_COLOR : '0;
                    if (int'(init_x) == BOARD_W - 1) begin
                        init_x <= '0;
                        if (int'(init_y) == BOARD_H - 1) begin
                            init_done_q <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            init_y <= init_y + YW'(1);
                        end
                    end else begin
                        init_x <= init_x + XW'(1);
                    end
                end
                S_IDLE: begin
                    if (pf.move_req && !game_over_q) begin
                        intent     <= pf.move_intent;
                        settle_cnt <= SW'(SETTLE_CYCLES - 1);
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_CHECK;
                    else settle_cnt <= settle_cnt - SW'(1);
                end
                S_CHECK: begin
                    if (!collide) begin
                        commit_q <= 1'b1;
                        state    <= S_IDLE;
                    end else if (intent) begin
                        declined_q <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        lock_idx <= '0;
                        state    <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (lock_top) begin
                        game_over_q <= 1'b1;
                        locked_q    <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        // Guard keeps walls and floor intact even for a malformed piece.
                        if (lock_x != '0 && int'(lock_x) < BOARD_W - 1 && int'(lock_y_up) < BOARD_H - 1)
                            field[lock_y_up][lock_x] <= pf.piece_color;
                        if (int'(lock_idx) == CELLS - 1) begin
                            scan_row <= YW'(BOARD_H - 2);
                            state    <= S_SCAN;
                        end else begin
                            lock_idx <= lock_idx + CW'(1);
                        end
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        shift_row <= scan_row;
                        state     <= S_SHIFT;
                    end else if (scan_row == '0) begin
                        locked_q <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        scan_row <= scan_row - YW'(1);
                    end
                end
                S_SHIFT: begin
                    if (shift_row != '0)
                        for (int c = 1; c < BOARD_W - 1; c++)
                            field[shift_row][XW'(c)] <= field[shift_row - YW'(1)][XW'(c)];
                    if (shift_row <= YW'(1)) begin
                        for (int c = 1; c < BOARD_W - 1; c++)
                            field[0][XW'(c)] <= '0;
                        if (lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
                        state <= S_SCAN;
                    end else begin
                        shift_row <= shift_row - YW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign pf.rd_color      = rd_val;
    assign pf.busy          = (state != S_IDLE);
    assign pf.move_commit   = commit_q;
    assign pf.move_declined = declined_q;
    assign pf.move_locked   = locked_q;
    assign pf.init_done     = init_done_q;
    assign pf.game_over     = game_over_q;
    assign pf.lines_cleared = lines_q;
endmodule
